// File: rtl/pixel_write_sink.sv
// pixel_write_sink: accepts pixel plots, queues them in a FIFO and drives the frame-buffer write port,
// with a hardware full-screen clear that sweeps every address.
module pixel_write_sink #(
    parameter int FIFO_DEPTH = 8,
    parameter int SCREEN_W   = 320,
    parameter int SCREEN_H   = 240,
    parameter int ADDR_W     = 17
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              plot,
    input  logic [8:0]        X,
    input  logic [7:0]        Y,
    input  logic [2:0]        color,
    output logic              ready,
    input  logic              clearScreen,
    input  logic [2:0]        clearColor,
    input  logic              clearOverflow,
    output logic              memWrite,
    output logic [ADDR_W-1:0] memAddr,
    output logic [2:0]        memData,
    output logic              busy,
    output logic              overflow,
    output logic              rangeError,
    output logic [ADDR_W-1:0] pixelCount
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] W_A = ADDR_W'(SCREEN_W);
    localparam logic [ADDR_W-1:0] H_A = ADDR_W'(SCREEN_H);
    localparam logic [ADDR_W:0] PIXELS = (ADDR_W+1)'(SCREEN_W * SCREEN_H);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t            state;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [2:0]        fifo_color [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    // One bit wider than the address so the sweep can step past the last pixel before leaving CLEAR
    logic [ADDR_W:0]   fill;
    logic [2:0]        fill_color;
    logic              in_range, push, pop;
    logic [ADDR_W-1:0] plot_addr;
    always_comb begin
        in_range  = (ADDR_W'(X) < W_A) && (ADDR_W'(Y) < H_A);
        plot_addr = ADDR_W'(Y) * W_A + ADDR_W'(X);
        ready     = (state == IDLE) && (count < (PW+1)'(FIFO_DEPTH));
        push      = plot && ready && in_range && !clearScreen;
        pop       = (state == IDLE) && (count != '0);
        busy      = (state == CLEAR) || (count != '0);
    end
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= plot_addr;
            fifo_color[wr_ptr] <= color;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fill       <= '0;
            fill_color <= '0;
            memWrite   <= 1'b0;
            memAddr    <= '0;
            memData    <= '0;
            overflow   <= 1'b0;
            rangeError <= 1'b0;
            pixelCount <= '0;
        end else begin
            overflow   <= (overflow && !clearOverflow) || (plot && !ready);
            rangeError <= (rangeError && !clearOverflow) || (plot && !in_range);
            if (clearScreen) begin
                state      <= CLEAR;
                fill       <= '0;
                fill_color <= clearColor;
                pixelCount <= '0;
                memWrite   <= 1'b0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
            end else if (state == CLEAR) begin
                if (fill == PIXELS) begin
                    state    <= IDLE;
                    memWrite <= 1'b0;
                end else begin
                    memWrite <= 1'b1;
                    memAddr  <= fill[ADDR_W-1:0];
                    memData  <= fill_color;
                    fill     <= fill + (ADDR_W+1)'(1);
                end
            end else begin
                memWrite <= pop;
                if (pop) begin
                    memAddr    <= fifo_addr[rd_ptr];
                    memData    <= fifo_color[rd_ptr];
                    rd_ptr     <= rd_ptr + PW'(1);
                    pixelCount <= pixelCount + ADDR_W'(pixelCount != '1);
                end
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                count <= count + (PW+1)'(push) - (PW+1)'(pop);
            end
        end
    end
endmodule

// File: tb/tb_pixel_write_sink.sv
// tb_pixel_write_sink: directed table and sequence checks for pixel_write_sink.
module tb_pixel_write_sink;
    logic        clock = 0, reset = 1, plot = 0, clearScreen = 0, clearOverflow = 0;
    logic [8:0]  X = '0;
    logic [7:0]  Y = '0;
    logic [2:0]  color = '0, clearColor = '0;
    logic        ready, memWrite, busy, overflow, rangeError;
    logic [16:0] memAddr, pixelCount;
    logic [2:0]  memData;
    int checks = 0, failures = 0;

    pixel_write_sink dut (
        .clock(clock), .reset(reset), .plot(plot), .X(X), .Y(Y), .color(color),
        .ready(ready), .clearScreen(clearScreen), .clearColor(clearColor),
        .clearOverflow(clearOverflow), .memWrite(memWrite), .memAddr(memAddr),
        .memData(memData), .busy(busy), .overflow(overflow), .rangeError(rangeError),
        .pixelCount(pixelCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        plot;
        logic [8:0]  x;
        logic [7:0]  y;
        logic [2:0]  c;
        logic        co;
        logic        mw;
        logic [16:0] addr;
        logic [2:0]  data;
        logic        busy;
        logic        rng;
        logic [16:0] pc;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        int nw, bad, rdy_bad;
        bit found;
        tick();
        tick();
        reset = 0;
        tick();

        // Reset in the middle of a clear sweep
        clearScreen = 1; clearColor = 3'd6;
        tick();
        clearScreen = 0;
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (memWrite && memAddr == 17'd1000) begin
                found = 1;
                break;
            end
        end
        chk("reach_fill_1000", 32'(found), 32'd1);
        #2 reset = 1;
        #1;
        chk("rst_memWrite", 32'(memWrite), 0);
        chk("rst_memAddr", 32'(memAddr), 0);
        chk("rst_memData", 32'(memData), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", {30'd0, overflow, rangeError}, 0);
        chk("rst_pixelCount", 32'(pixelCount), 0);
        tick();
        reset = 0;
        tick();
        chk("post_rst_ready", 32'(ready), 1);
        chk("post_rst_busy", 32'(busy), 0);
        plot = 1; X = 9'd5; Y = 8'd2; color = 3'd3;
        tick();
        plot = 0;
        chk("post_rst_lat1_mw", 32'(memWrite), 0);
        tick();
        chk("post_rst_mw", 32'(memWrite), 1);
        chk("post_rst_addr", 32'(memAddr), 645);
        chk("post_rst_data", 32'(memData), 3);

        // Table of single-cycle IDLE behaviour from a fresh reset
        tbl[0] = '{1'b1, 9'd319, 8'd239, 3'd7, 1'b0, 1'b0, 17'd0,     3'd0, 1'b1, 1'b0, 17'd0};
        tbl[1] = '{1'b0, 9'd0,   8'd0,   3'd0, 1'b0, 1'b1, 17'd76799, 3'd7, 1'b0, 1'b0, 17'd1};
        tbl[2] = '{1'b0, 9'd0,   8'd0,   3'd0, 1'b0, 1'b0, 17'd0,     3'd0, 1'b0, 1'b0, 17'd1};
        tbl[3] = '{1'b1, 9'd320, 8'd0,   3'd2, 1'b0, 1'b0, 17'd0,     3'd0, 1'b0, 1'b1, 17'd1};
        tbl[4] = '{1'b1, 9'd0,   8'd240, 3'd2, 1'b0, 1'b0, 17'd0,     3'd0, 1'b0, 1'b1, 17'd1};
        tbl[5] = '{1'b0, 9'd0,   8'd0,   3'd0, 1'b1, 1'b0, 17'd0,     3'd0, 1'b0, 1'b0, 17'd1};
        tbl[6] = '{1'b1, 9'd5,   8'd2,   3'd3, 1'b0, 1'b0, 17'd0,     3'd0, 1'b1, 1'b0, 17'd1};
        tbl[7] = '{1'b1, 9'd1,   8'd0,   3'd1, 1'b0, 1'b1, 17'd645,   3'd3, 1'b1, 1'b0, 17'd2};
        tbl[8] = '{1'b1, 9'd320, 8'd5,   3'd4, 1'b1, 1'b1, 17'd1,     3'd1, 1'b0, 1'b1, 17'd3};
        tbl[9] = '{1'b0, 9'd0,   8'd0,   3'd0, 1'b0, 1'b0, 17'd0,     3'd0, 1'b0, 1'b1, 17'd3};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            plot = tbl[i].plot; X = tbl[i].x; Y = tbl[i].y; color = tbl[i].c;
            clearOverflow = tbl[i].co;
            chk($sformatf("tbl%0d_ready", i), 32'(ready), 1);
            tick();
            chk($sformatf("tbl%0d_mw", i), 32'(memWrite), 32'(tbl[i].mw));
            if (tbl[i].mw) begin
                chk($sformatf("tbl%0d_addr", i), 32'(memAddr), 32'(tbl[i].addr));
                chk($sformatf("tbl%0d_data", i), 32'(memData), 32'(tbl[i].data));
            end
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_range", i), 32'(rangeError), 32'(tbl[i].rng));
            chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 0);
            chk($sformatf("tbl%0d_pc", i), 32'(pixelCount), 32'(tbl[i].pc));
        end
        plot = 0; clearOverflow = 0;

        // Burst of 20 back-to-back plots on row 10
        for (int i = 0; i < 20; i++) begin
            plot = 1; X = 9'(i); Y = 8'd10; color = 3'(i);
            chk($sformatf("burst%0d_ready", i), 32'(ready), 1);
            tick();
            if (i > 0) begin
                chk($sformatf("burst%0d_mw", i), 32'(memWrite), 1);
                chk($sformatf("burst%0d_addr", i), 32'(memAddr), 32'(3200 + i - 1));
            end
        end
        plot = 0;
        tick();
        chk("burst_last_mw", 32'(memWrite), 1);
        chk("burst_last_addr", 32'(memAddr), 3219);
        chk("burst_last_data", 32'(memData), 3);
        tick();
        chk("burst_end_mw", 32'(memWrite), 0);
        chk("burst_end_busy", 32'(busy), 0);
        chk("burst_ovf", 32'(overflow), 0);
        chk("burst_pc", 32'(pixelCount), 23);

        // Full clear with a plot held high the whole time
        plot = 1; X = 9'd7; Y = 8'd0; color = 3'd5;
        clearScreen = 1; clearColor = 3'd2;
        tick();
        clearScreen = 0;
        chk("clr_start_mw", 32'(memWrite), 0);
        chk("clr_start_pc", 32'(pixelCount), 0);
        chk("clr_start_ready", 32'(ready), 0);
        nw = 0; bad = 0; rdy_bad = 0;
        for (int i = 0; i < 80000; i++) begin
            tick();
            if (memWrite) begin
                if (memAddr !== 17'(nw) || memData !== 3'd2) bad++;
                nw++;
            end
            if (ready !== 1'b0) rdy_bad++;
            if (nw == 76800) break;
        end
        chk("clr_writes", 32'(nw), 76800);
        chk("clr_bad_writes", 32'(bad), 0);
        chk("clr_ready_high", 32'(rdy_bad), 0);
        tick();
        chk("clr_done_mw", 32'(memWrite), 0);
        chk("clr_done_ready", 32'(ready), 1);
        chk("clr_done_busy", 32'(busy), 0);
        chk("clr_done_pc", 32'(pixelCount), 0);
        chk("clr_done_ovf", 32'(overflow), 1);
        tick();
        plot = 0;
        chk("clr_accept_mw", 32'(memWrite), 0);
        chk("clr_accept_busy", 32'(busy), 1);
        tick();
        chk("clr_plot_mw", 32'(memWrite), 1);
        chk("clr_plot_addr", 32'(memAddr), 7);
        chk("clr_plot_data", 32'(memData), 5);
        chk("clr_plot_pc", 32'(pixelCount), 1);

        // Clear issued while plots are pending, then restarted mid-sweep
        plot = 1; X = 9'd1; Y = 8'd1; color = 3'd1;
        tick();
        X = 9'd2; color = 3'd2;
        tick();
        chk("stall_p1_mw", 32'(memWrite), 1);
        chk("stall_p1_addr", 32'(memAddr), 321);
        X = 9'd3; color = 3'd4; clearScreen = 1; clearColor = 3'd3;
        tick();
        plot = 0; clearScreen = 0;
        chk("stall_clr_mw", 32'(memWrite), 0);
        chk("stall_clr_ready", 32'(ready), 0);
        tick();
        chk("stall_first_mw", 32'(memWrite), 1);
        chk("stall_first_addr", 32'(memAddr), 0);
        chk("stall_first_data", 32'(memData), 3);
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (memWrite && memAddr == 17'd500) begin
                found = 1;
                break;
            end
        end
        chk("stall_reach_500", 32'(found), 1);
        clearScreen = 1; clearColor = 3'd4;
        tick();
        clearScreen = 0;
        chk("restart_mw", 32'(memWrite), 0);
        tick();
        chk("restart_mw2", 32'(memWrite), 1);
        chk("restart_addr", 32'(memAddr), 0);
        chk("restart_data", 32'(memData), 4);
        tick();
        chk("restart_addr1", 32'(memAddr), 1);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
